led_blinker_multi: RTL and testbench

//  Parametrised multi-channel LED driver, successor to the single-LED 1 Hz blinker.
//  A shared prescaler generates a tick; each channel runs OFF, ON, free BLINK or counted BURST mode.

---
 rtl/led_blinker_multi.sv | 157 +++++++++++++++
 tb/tb_led_blinker_multi.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: a shared prescaler tick drives per-channel OFF/ON/BLINK/BURST engines,
// each reconfigured at run time through a valid/ready load port.
module led_blinker_multi #(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int HP_W    = 12,
  parameter int BURST_W = 4
) (
  input  logic                                    CLOCK_50,
  input  logic                                    reset,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] cfg_ch,
  input  logic [1:0]                              cfg_mode,
  input  logic [HP_W-1:0]                         cfg_half,
  input  logic [BURST_W-1:0]                      cfg_burst,
  output logic [NUM_CH-1:0]                       LED,
  output logic [NUM_CH-1:0]                       busy,
  output logic [NUM_CH-1:0]                       burst_done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CH_W     = $clog2(NUM_CH > 1 ? NUM_CH : 2);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  logic [PW-1:0] presc_r;
  logic          cfg_ready_r;
  logic          tick_s;
  logic          accept_s;

  assign tick_s    = (presc_r == PW'(TICK_DIV - 1));
  assign accept_s  = cfg_valid & cfg_ready_r;
  assign cfg_ready = cfg_ready_r;

  // Free-running prescaler; config loads never disturb its phase.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Ready drops for exactly one cycle after each accepted load.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cfg_ready_r <= 1'b1;
    end else if (accept_s) begin
      cfg_ready_r <= 1'b0;
    end else begin
      cfg_ready_r <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e              mode_r;
    logic [HP_W-1:0]    half_r;
    logic [HP_W-1:0]    cnt_r;
    logic [BURST_W-1:0] rem_r;
    logic               led_r;
    logic               busy_r;
    logic               done_r;
    logic               load_s;

    // Out-of-range channel numbers match no engine and are dropped silently.
    assign load_s        = accept_s && (cfg_ch == CH_W'(i));
    assign LED[i]        = led_r;
    assign busy[i]       = busy_r;
    assign burst_done[i] = done_r;

    // Channel engine: a load overrides any tick arriving on the same edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
        mode_r <= MODE_OFF;
        half_r <= HP_W'(1);
        cnt_r  <= '0;
        rem_r  <= '0;
        led_r  <= 1'b0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (load_s) begin
          half_r <= (cfg_half == '0) ? HP_W'(1) : cfg_half;
          cnt_r  <= '0;
          case (cfg_mode)
            MODE_ON: begin
              mode_r <= MODE_ON;
              led_r  <= 1'b1;
              busy_r <= 1'b0;
              rem_r  <= '0;
            end
            MODE_BLINK: begin
              mode_r <= MODE_BLINK;
              led_r  <= 1'b1;
              busy_r <= 1'b0;
              rem_r  <= '0;
            end
            MODE_BURST: begin
              if (cfg_burst == '0) begin
                mode_r <= MODE_OFF;
                led_r  <= 1'b0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                rem_r  <= '0;
              end else begin
                mode_r <= MODE_BURST;
                led_r  <= 1'b1;
                busy_r <= 1'b1;
                rem_r  <= cfg_burst;
              end
            end
            default: begin
              mode_r <= MODE_OFF;
              led_r  <= 1'b0;
              busy_r <= 1'b0;
              rem_r  <= '0;
            end
          endcase
        end else if (tick_s && ((mode_r == MODE_BLINK) || (mode_r == MODE_BURST))) begin
          if (cnt_r == half_r - HP_W'(1)) begin
            cnt_r <= '0;
            // In a burst only the falling edge consumes a pulse.
            if ((mode_r == MODE_BURST) && led_r) begin
              led_r <= 1'b0;
              if (rem_r <= BURST_W'(1)) begin
                rem_r  <= '0;
                busy_r <= 1'b0;
                done_r <= 1'b1;
                mode_r <= MODE_OFF;
              end else begin
                rem_r <= rem_r - BURST_W'(1);
              end
            end else begin
              led_r <= ~led_r;
            end
          end else begin
            cnt_r <= cnt_r + HP_W'(1);
          end
        end else begin
          cnt_r <= cnt_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed bench for led_blinker_multi with TICK_DIV=10; expected values are hand-derived
// from the load edge and the prescaler phase tracked by the bench.
module tb_led_blinker_multi;

  logic        CLOCK_50;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [11:0] cfg_half;
  logic [3:0]  cfg_burst;
  logic [3:0]  LED;
  logic [3:0]  busy;
  logic [3:0]  burst_done;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  led_blinker_multi #(
    .NUM_CH(4), .CLK_HZ(10), .TICK_HZ(1), .HP_W(12), .BURST_W(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_burst(cfg_burst),
    .LED(LED), .busy(busy), .burst_done(burst_done)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Edges since reset release; edges%10 mirrors the expected prescaler count.
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Returns #1 after the accepting edge; align=1 makes the accepting edge a tick edge.
  task automatic load(input logic [1:0] ch, input logic [1:0] mode, input logic [11:0] half,
                      input logic [3:0] burst, input bit align);
    if (!cfg_ready) step(1);
    if (align) begin
      for (int k = 0; k < 10; k++) begin
        if ((edges % 10) == 9) break;
        step(1);
      end
    end
    cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_burst = burst;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_mode = 2'd0;
    cfg_half = 12'd0; cfg_burst = 4'd0;
    repeat (5) @(posedge CLOCK_50);
    #1;
    n_checks++; if (LED !== 4'b0000) begin n_fail++; $display("FAIL reset_led: got %b expected 0000", LED); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    reset = 1'b0;
    step(3);
    n_checks++; if (LED !== 4'b0000) begin n_fail++; $display("FAIL post_reset_led: got %b expected 0000", LED); end
    n_checks++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0000", busy); end
    n_checks++; if (burst_done !== 4'b0000) begin n_fail++; $display("FAIL post_reset_done: got %b expected 0000", burst_done); end
  endtask

  task automatic test_blink();
    load(2'd0, 2'b10, 12'd3, 4'd0, 1'b1);
    n_checks++; if (LED !== 4'b0001) begin n_fail++; $display("FAIL blink_load: LED=%b expected 0001", LED); end
    step(29);
    n_checks++; if (LED[0] !== 1'b1) begin n_fail++; $display("FAIL blink_t29: LED0=%b expected 1", LED[0]); end
    step(1);
    n_checks++; if (LED !== 4'b0000) begin n_fail++; $display("FAIL blink_t30: LED=%b expected 0000", LED); end
    step(29);
    n_checks++; if (LED[0] !== 1'b0) begin n_fail++; $display("FAIL blink_t59: LED0=%b expected 0", LED[0]); end
    step(1);
    n_checks++; if (LED[0] !== 1'b1) begin n_fail++; $display("FAIL blink_t60: LED0=%b expected 1", LED[0]); end
  endtask

  task automatic test_burst();
    int high_c, rise_c, done_c, done_at, busy_c;
    logic prev;
    high_c = 0; rise_c = 0; done_c = 0; done_at = -1; busy_c = 0; prev = 1'b0;
    load(2'd1, 2'b11, 12'd1, 4'd3, 1'b1);
    for (int i = 0; i < 60; i++) begin
      if (LED[1]) high_c++;
      if (LED[1] && !prev) rise_c++;
      if (busy[1]) busy_c++;
      if (burst_done[1]) begin done_c++; done_at = i; end
      prev = LED[1];
      step(1);
    end
    n_checks++; if (rise_c != 3) begin n_fail++; $display("FAIL burst_pulses: got %0d expected 3", rise_c); end
    n_checks++; if (high_c != 30) begin n_fail++; $display("FAIL burst_high_cycles: got %0d expected 30", high_c); end
    n_checks++; if (busy_c != 50) begin n_fail++; $display("FAIL burst_busy_cycles: got %0d expected 50", busy_c); end
    n_checks++; if (done_c != 1) begin n_fail++; $display("FAIL burst_done_count: got %0d expected 1", done_c); end
    n_checks++; if (done_at != 50) begin n_fail++; $display("FAIL burst_done_time: got %0d expected 50", done_at); end
    n_checks++; if ({LED[1], busy[1]} !== 2'b00) begin n_fail++; $display("FAIL burst_end_state: got %b expected 00", {LED[1], busy[1]}); end
  endtask

  task automatic test_burst_zero();
    load(2'd2, 2'b11, 12'd1, 4'd0, 1'b0);
    n_checks++; if (burst_done[2] !== 1'b1) begin n_fail++; $display("FAIL bz_done: got %b expected 1", burst_done[2]); end
    n_checks++; if ({LED[2], busy[2]} !== 2'b00) begin n_fail++; $display("FAIL bz_led_busy: got %b expected 00", {LED[2], busy[2]}); end
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL bz_ready_low: got %b expected 0", cfg_ready); end
    step(1);
    n_checks++; if (burst_done[2] !== 1'b0) begin n_fail++; $display("FAIL bz_done_width: got %b expected 0", burst_done[2]); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL bz_ready_back: got %b expected 1", cfg_ready); end
  endtask

  task automatic test_burst_abort();
    int low_c, busy_c, done_c;
    low_c = 0; busy_c = 0; done_c = 0;
    load(2'd1, 2'b11, 12'd1, 4'd5, 1'b1);
    step(35);
    n_checks++; if ({LED[1], busy[1]} !== 2'b01) begin n_fail++; $display("FAIL abort_pre: got %b expected 01", {LED[1], busy[1]}); end
    load(2'd1, 2'b01, 12'd1, 4'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (!LED[1]) low_c++;
      if (busy[1]) busy_c++;
      if (burst_done[1]) done_c++;
      step(1);
    end
    n_checks++; if (low_c != 0) begin n_fail++; $display("FAIL abort_led_low_cycles: got %0d expected 0", low_c); end
    n_checks++; if (busy_c != 0) begin n_fail++; $display("FAIL abort_busy_cycles: got %0d expected 0", busy_c); end
    n_checks++; if (done_c != 0) begin n_fail++; $display("FAIL abort_done_count: got %0d expected 0", done_c); end
  endtask

  task automatic test_half_zero();
    load(2'd3, 2'b10, 12'd0, 4'd0, 1'b1);
    n_checks++; if (LED[3] !== 1'b1) begin n_fail++; $display("FAIL hz_load: got %b expected 1", LED[3]); end
    step(9);
    n_checks++; if (LED[3] !== 1'b1) begin n_fail++; $display("FAIL hz_t9: got %b expected 1", LED[3]); end
    step(1);
    n_checks++; if (LED[3] !== 1'b0) begin n_fail++; $display("FAIL hz_t10: got %b expected 0", LED[3]); end
    step(10);
    n_checks++; if (LED[3] !== 1'b1) begin n_fail++; $display("FAIL hz_t20: got %b expected 1", LED[3]); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] modes [6];
    logic       exp_rdy [6];
    logic       exp_led [6];
    modes   = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_led = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    step(1);
    cfg_ch = 2'd3; cfg_half = 12'd1; cfg_burst = 4'd0;
    cfg_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cfg_mode = modes[j];
      n_checks++; if (cfg_ready !== exp_rdy[j]) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", j, cfg_ready, exp_rdy[j]); end
      step(1);
      n_checks++; if (LED[3] !== exp_led[j]) begin n_fail++; $display("FAIL b2b_led[%0d]: got %b expected %b", j, LED[3], exp_led[j]); end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid_blink();
    load(2'd0, 2'b10, 12'd3, 4'd0, 1'b1);
    load(2'd1, 2'b11, 12'd2, 4'd4, 1'b0);
    step(3);
    n_checks++; if ({LED[0], busy[1]} !== 2'b11) begin n_fail++; $display("FAIL mid_pre_reset: got %b expected 11", {LED[0], busy[1]}); end
    reset = 1'b1;
    #1;
    n_checks++; if (LED !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_led: got %b expected 0000", LED); end
    n_checks++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0000", busy); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", cfg_ready); end
    step(3);
    reset = 1'b0;
    step(25);
    n_checks++; if ({LED, busy, burst_done} !== 12'h000) begin n_fail++; $display("FAIL after_reset_idle: got %h expected 000", {LED, busy, burst_done}); end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_burst();
    test_burst_zero();
    test_burst_abort();
    test_half_zero();
    test_back_to_back();
    test_reset_mid_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
